// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   INST_W        instruction width
//   REDIR_W       redirect bus width: {valid, target}
//   RESET_PC_DEF  default first fetch target
//   iq_entry_t    instruction-queue entry {pc, inst}
//   redirect_t    redirect bus {valid, target}
package fetch_unit_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned REDIR_W = 1 + 32;
  localparam logic [31:0] RESET_PC_DEF = 32'hbfc0_0000;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } iq_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] target;
  } redirect_t;

  // Redirect targets are word addresses; the byte offset is ignored.
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Instruction queue: circular FIFO of {pc, inst} entries.
//   clk, rst    clock, synchronous active-high reset
//   clr         drop all contents (redirect); wins over push and pop
//   push_cnt    number of valid entries in push_data (packed from index 0)
//   push_data   up to FETCH_N entries, oldest at index 0
//   pop         remove the head; ignored when empty
//   head_valid  queue not empty
//   head        oldest entry
//   count       occupancy
module inst_queue
  import fetch_unit_pkg::*;
#(
  parameter int FETCH_N  = 2,
  parameter int IQ_DEPTH = 8,
  localparam int PW = $clog2(IQ_DEPTH),
  localparam int CW = PW + 1,
  localparam int NW = $clog2(FETCH_N) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [NW-1:0]             push_cnt,
  input  iq_entry_t [FETCH_N-1:0]   push_data,
  input  logic                      pop,
  output logic                      head_valid,
  output iq_entry_t                 head,
  output logic [CW-1:0]             count
);

  iq_entry_t [IQ_DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  always_comb begin
    mem_d  = mem_q;
    do_pop = pop && (count_q != '0);
    // Pointer arithmetic is PW bits wide, so slot indices wrap naturally.
    for (int j = 0; j < FETCH_N; j++) begin
      if (j < int'(push_cnt)) mem_d[wr_ptr_q + PW'(j)] = push_data[j];
    end
    wr_ptr_d = wr_ptr_q + PW'(push_cnt);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(push_cnt) - CW'(do_pop);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_valid = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues block reads to a 1-cycle-latency
// instruction SRAM and feeds an instruction queue toward ID.
//   clk, rst          clock, synchronous active-high reset
//   flush, new_pc     exception redirect (priority over branch)
//   br_e, br_addr     branch redirect
//   inst_sram_*       SRAM read port; writes are never issued
//   id_valid/ready    head handshake toward ID; id_pc/id_inst = head
//   iq_count          queue occupancy
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          FETCH_N  = 2,
  parameter int          IQ_DEPTH = 8,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  localparam int CW = $clog2(IQ_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [31:0]             new_pc,
  input  logic                    br_e,
  input  logic [31:0]             br_addr,
  output logic                    inst_sram_en,
  output logic [3:0]              inst_sram_wen,
  output logic [31:0]             inst_sram_addr,
  output logic [31:0]             inst_sram_wdata,
  input  logic [32*FETCH_N-1:0]   inst_sram_rdata,
  output logic                    id_valid,
  input  logic                    id_ready,
  output logic [31:0]             id_pc,
  output logic [INST_W-1:0]       id_inst,
  output logic [CW-1:0]           iq_count
);

  localparam int          OW        = (FETCH_N > 1) ? $clog2(FETCH_N) : 1;
  localparam int          NW        = $clog2(FETCH_N) + 1;
  localparam logic [31:0] BLK_BYTES = 32'(4 * FETCH_N);
  localparam logic [31:0] ADDR_MASK = ~(BLK_BYTES - 32'd1);

  logic [31:0]   fpc_q, fpc_d;
  logic          inflight_q, inflight_d;
  logic [OW-1:0] req_off_q, req_off_d;
  logic [31:0]   req_base_q, req_base_d;

  redirect_t                redir;
  logic [OW-1:0]            cur_off;
  logic [31:0]              need;
  logic [NW-1:0]            push_cnt;
  iq_entry_t [FETCH_N-1:0]  push_data;
  iq_entry_t                iq_head;
  logic                     iq_head_valid;
  logic                     pop;

  assign redir.valid  = flush | br_e;
  assign redir.target = flush ? new_pc : br_addr;

  assign inst_sram_addr  = fpc_q & ADDR_MASK;
  assign cur_off         = OW'((fpc_q >> 2) & 32'(FETCH_N - 1));
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'h0;

  // Space check reserves room for the block already in flight; a pop in
  // the same cycle is deliberately not credited.
  always_comb begin
    need = 32'(iq_count) + (inflight_q ? 32'(FETCH_N) : 32'd0) + 32'(FETCH_N);
    inst_sram_en = !rst && !redir.valid && (need <= 32'(IQ_DEPTH));
  end

  // Response cycle: compact slots offset..FETCH_N-1 down to index 0.
  // A redirect in the response cycle discards the block.
  always_comb begin
    push_data = '0;
    push_cnt  = '0;
    if (inflight_q && !redir.valid) begin
      push_cnt = NW'(FETCH_N - int'(req_off_q));
      for (int j = 0; j < FETCH_N; j++) begin
        if (int'(req_off_q) + j < FETCH_N) begin
          push_data[j].pc   = req_base_q + 32'(4 * (int'(req_off_q) + j));
          push_data[j].inst = inst_sram_rdata[32*(int'(req_off_q)+j) +: 32];
        end
      end
    end
  end

  always_comb begin
    fpc_d      = fpc_q;
    inflight_d = inst_sram_en;
    req_off_d  = req_off_q;
    req_base_d = req_base_q;
    if (redir.valid) begin
      fpc_d = align_word(redir.target);
    end else if (inst_sram_en) begin
      fpc_d      = inst_sram_addr + BLK_BYTES;
      req_off_d  = cur_off;
      req_base_d = inst_sram_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q      <= RESET_PC;
      inflight_q <= 1'b0;
      req_off_q  <= '0;
      req_base_q <= '0;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
      req_off_q  <= req_off_d;
      req_base_q <= req_base_d;
    end
  end

  inst_queue #(
    .FETCH_N  (FETCH_N),
    .IQ_DEPTH (IQ_DEPTH)
  ) u_inst_queue (
    .clk        (clk),
    .rst        (rst),
    .clr        (redir.valid),
    .push_cnt   (push_cnt),
    .push_data  (push_data),
    .pop        (pop),
    .head_valid (iq_head_valid),
    .head       (iq_head),
    .count      (iq_count)
  );

  assign id_valid = !rst && iq_head_valid;
  assign pop      = id_valid && id_ready;
  assign id_pc    = id_valid ? iq_head.pc   : 32'h0;
  assign id_inst  = id_valid ? iq_head.inst : '0;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter FETCH_N, default 2, meaning instructions per fetch block; legal values are 1, 2 and 4.
REQ-002 SHALL have parameter IQ_DEPTH, default 8, meaning instruction-queue entries; it SHALL be a power of 2 and at least 2*FETCH_N.
REQ-003 SHALL have parameter RESET_PC, default 32'hbfc0_0000, meaning the first fetch target.
REQ-004 SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-005 SHALL have the following ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  exception redirect.
- new_pc  in  32  flush target.
- br_e  in  1  branch redirect.
- br_addr  in  32  branch target.
- inst_sram_en  out  1  read request.
- inst_sram_wen  out  4  write enable; tied to 0.
- inst_sram_addr  out  32  block-aligned read address.
- inst_sram_wdata  out  32  write data; tied to 0.
- inst_sram_rdata  in  32*FETCH_N  block data; slot k occupies bits [32k+31:32k].
- id_valid  out  1  queue head valid.
- id_ready  in  1  ID accepts the head.
- id_pc  out  32  PC of the head instruction.
- id_inst  out  32  head instruction.
- iq_count  out  clog2(IQ_DEPTH)+1  queue occupancy.

Function
REQ-006 SHALL hold fetch PC register fpc; A = clog2(FETCH_N)+2; inst_sram_addr = {fpc[31:A], A'b0}.
REQ-007 SHALL treat SRAM read latency as exactly 1 cycle: rdata is valid in the cycle after the en=1 cycle.
REQ-008 SHALL keep an in-flight flag, set by an issue and cleared by the response cycle.
REQ-009 SHALL drive inst_sram_en combinationally, equal to !rst & !flush & !br_e & (iq_count + inflight*FETCH_N + FETCH_N <= IQ_DEPTH).
- The same-cycle pop is not credited.
REQ-010 On issue, SHALL set fpc <= inst_sram_addr + 4*FETCH_N.
REQ-011 SHALL record the issued slot offset fpc[A-1:2] and base address with each request.
REQ-012 On response, SHALL push slots offset..FETCH_N-1, in ascending order, with pc = base + 4k.
- Slots below offset are discarded, covering unaligned branch targets.
REQ-013 SHALL give flush priority over br_e; redirect target T = flush ? new_pc : br_addr, with T[1:0] ignored (treated as 00).
REQ-014 On redirect in cycle N: queue cleared, in-flight response (arriving in N or N+1) discarded, fpc <= T, en=0 in N.
- First fetch of T issues in N+1.
REQ-015 SHALL assert id_valid = (iq_count != 0) and present the head on id_pc/id_inst; id_pc and id_inst SHALL be 0 when id_valid=0.
REQ-016 SHALL pop the head when id_valid & id_ready; a pop in a redirect cycle SHALL complete, and the clear SHALL win.
REQ-017 SHALL allow push and pop in the same cycle; iq_count += pushed - popped.
REQ-018 Pointers SHALL wrap modulo IQ_DEPTH; overflow is impossible by REQ-009, and popping empty is a no-op.
REQ-019 SHALL drive no SRAM writes: wen=0, wdata=0 always.

Reset
REQ-020 During rst, SHALL set fpc=RESET_PC, iq_count=0, inflight=0, pointers=0.
- Outputs: en=0, id_valid=0, id_pc=0, id_inst=0.
- Any response arriving in the cycle after rst SHALL be dropped.
REQ-021 SHALL raise inst_sram_en with addr = aligned RESET_PC in the first cycle after rst deasserts.
REQ-022 rst mid-operation SHALL abandon queue contents and in-flight requests with no residual pushes.

Structure
REQ-023 RESET_PC, the redirect bus width (1+32 bits, {br_e, br_addr}) and the instruction width SHALL live in the shared defines header.
REQ-024 SHALL instantiate one sub-module, inst_queue: a FIFO with multi-slot push (up to FETCH_N entries) and single pop, holding {pc, inst}.

Verification
REQ-025 Build FETCH_N=2, IQ_DEPTH=8. Release rst with id_ready=1 and rdata={inst1,inst0}:
- -> addr bfc00000, then bfc00008.
- -> ID sees pc bfc00000, bfc00004, bfc00008 in order.
REQ-026 Hold id_ready=0:
- -> en falls after 4 issued blocks; iq_count=8; no overwrite.
- Raise id_ready -> 8 entries drain in order, then fetch resumes.
REQ-027 br_e=1, br_addr=bfc00104 with a request in flight:
- -> the response is dropped; next addr bfc00100.
- -> only pc bfc00104 is queued from that block.
REQ-028 flush=1, new_pc=bfc00380, together with br_e=1, br_addr=bfc00200:
- -> next addr bfc00380; queue empty one cycle later.
REQ-029 rst pulse with iq_count=5 and a request in flight:
- -> next cycle iq_count=0, id_valid=0, addr bfc00000; the stale response is ignored.
REQ-030 Builds FETCH_N=1 and FETCH_N=4 (IQ_DEPTH=8):
- -> addr stride 4 and 16 respectively.
- -> id_pc stride 4; iq_count never exceeds 8.
